rx_capture_fifo: RTL and testbench
==================================

Name: rx_capture_fifo

Overview:
- Parametrised successor to the receiver's single-word terminator stage; sits between the UART receive control and the consumer.
- Edge-captures each completed frame (data plus error flag) into a DEPTH-entry show-ahead FIFO with a valid/ack pop handshake.
- Generates a programmable-length active-low reset pulse to the receiver modules after every frame.
- Tracks overrun (frame lost because the FIFO was full) as a sticky flag.

Parameters:
- DATA_W, 8, frame data width.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- RST_PULSE, 2, cycles rst is held low after each captured frame; 0 disables the pulse.

Ports:
- Bclkx16_  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- Rx_done  in  1  frame-complete from receive control; may be held high for several cycles.
- Rx_err  in  1  framing/parity error for the frame; sampled together with Rx_done.
- data  in  DATA_W  received frame from the shift register.
- dis_ack  in  1  consumer pop request.
- clr_ovr  in  1  clears overrun.
- rst  out  1  active-low reset to the receiver modules.
- dis  out  DATA_W  head-of-FIFO data.
- dis_err  out  1  error flag of the head entry.
- dis_valid  out  1  FIFO non-empty.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overrun  out  1  sticky lost-frame flag.

Behaviour:
- Reset (reset=0 at posedge):
  - rst=0, dis=0, dis_err=0, dis_valid=0, count=0, overrun=0.
  - Read and write pointers = 0; pulse counter = 0; Rx_done edge register = 1.
  - Reset overrides every other input in the same cycle.
- Reset release: rst=1 from the first posedge with reset=1, unless a pulse starts that cycle.
- Capture:
  - A push event occurs at a posedge where Rx_done=1 and the previous sampled Rx_done was 0.
  - Only one push per Rx_done high period.
  - Because the edge register resets to 1, an Rx_done already high when reset is released is not captured.
- Push writes {Rx_err, data} sampled at the same edge.
- Latency: for an empty FIFO, dis/dis_err/dis_valid/count update at the push edge and are visible on the next cycle.
- FIFO outputs:
  - Show-ahead: dis/dis_err always present the head entry while dis_valid=1.
  - dis=0 and dis_err=0 when empty.
- Pop: occurs at a posedge with dis_ack=1 and dis_valid=1. dis_ack while empty is ignored.
- Full, push without pop: the frame is dropped, memory and count are unchanged, and overrun is set.
- Full, push and pop in the same cycle: both are performed, count stays DEPTH, no overrun.
- Empty, push and ack in the same cycle: the push is performed, the ack is ignored, count becomes 1.
- Pointers wrap modulo DEPTH. count increments on push only, decrements on pop only, and is unchanged on both.
- overrun: cleared by clr_ovr=1. If a drop occurs in the same cycle as clr_ovr, set wins and overrun stays 1.
- Reset-pulse FSM, states IDLE and PULSE:
  - IDLE -> PULSE on a push event (including a dropped one) when RST_PULSE>0. The counter loads RST_PULSE.
  - rst is registered: low starting the cycle after the event, for exactly RST_PULSE cycles.
  - In PULSE, the counter decrements each cycle. The state returns to IDLE and rst=1 when the counter reaches 0.
  - A new push event during PULSE reloads the counter, extending rst low.
  - With RST_PULSE=0 the FSM stays in IDLE and rst stays 1 outside reset.
- Reset asserted mid-pulse or mid-FIFO operation: all state returns to the reset values above, and FIFO contents are discarded (count=0).

Test Plan:
- Reset, then Rx_done high for 3 cycles with data=8'hA5, Rx_err=0 -> one entry only. Next cycle: dis=8'hA5, dis_valid=1, count=1. rst low exactly 2 cycles then 1.
- Push 8'h11, 8'h22, 8'h33 (8'h22 with Rx_err=1), then three single-cycle dis_ack -> dis reads 11/22/33 in order, dis_err=1 only for 8'h22, count goes 3,2,1,0, dis_valid=0 and dis=0 at the end.
- Push 5 frames 8'h01..8'h05 with no acks, DEPTH=4 -> count=4, overrun=1, 8'h05 lost, drains 01..04.
- clr_ovr=1 in the same cycle as a dropped push -> overrun stays 1; clr_ovr alone next cycle -> overrun=0.
- Full FIFO, push 8'hEE with dis_ack=1 the same cycle -> count stays 4, overrun=0, 8'hEE drained last. Empty FIFO, push 8'h7C with dis_ack=1 -> count=1, dis=8'h7C.
- Second Rx_done edge during an rst pulse -> rst low extended to 2 cycles after the second event. Reset asserted with count=3 mid-pulse -> count=0, dis_valid=0, rst=0; after release rst=1. With RST_PULSE=0 -> rst never drops after frames.

Source files
------------

// File: rtl/rx_capture_fifo.sv
// rx_capture_fifo
// Captures every completed receive frame (data plus error flag) into a
// DEPTH-entry show-ahead FIFO that the consumer drains with a valid/ack
// handshake. After each frame it pulses the active-low receiver reset for
// RST_PULSE cycles. A frame that arrives while the FIFO is full is lost and
// raises a sticky overrun flag.
//
// Ports:
//   Bclkx16_   clock, everything on its rising edge
//   reset      synchronous, active-low
//   Rx_done    frame complete; only its rising edge pushes
//   Rx_err     error flag of the frame, sampled with Rx_done
//   data       received frame
//   dis_ack    pop request; ignored while empty
//   clr_ovr    clears overrun (a drop in the same cycle wins)
//   rst        active-low reset pulse to the receiver modules
//   dis        head-of-FIFO data, 0 when empty
//   dis_err    head-of-FIFO error flag, 0 when empty
//   dis_valid  FIFO not empty
//   count      occupancy, 0..DEPTH
//   overrun    sticky lost-frame flag
module rx_capture_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int RST_PULSE = 2
) (
  input  logic                     Bclkx16_,
  input  logic                     reset,
  input  logic                     Rx_done,
  input  logic                     Rx_err,
  input  logic [DATA_W-1:0]        data,
  input  logic                     dis_ack,
  input  logic                     clr_ovr,
  output logic                     rst,
  output logic [DATA_W-1:0]        dis,
  output logic                     dis_err,
  output logic                     dis_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PC_W  = (RST_PULSE > 0) ? $clog2(RST_PULSE + 1) : 1;

  typedef enum logic {IDLE, PULSE} state_t;

  logic [DATA_W:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             rx_done_reg;
  logic             overrun_reg;
  logic             rst_reg;
  state_t           state_reg, state_next;
  logic [PC_W-1:0]  pulse_cnt_reg, pulse_cnt_next;

  logic             push_ev, full, empty, pop, push, drop;
  logic [DATA_W:0]  head;

  // Edge detect: the register resets to 1 so a level already high at
  // reset release is not taken as a new frame.
  assign push_ev = Rx_done & ~rx_done_reg;
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign pop     = dis_ack & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = push_ev & (~full | pop);
  assign drop    = push_ev & full & ~pop;

  // Contents carry no reset; occupancy alone decides what is valid.
  always_ff @(posedge Bclkx16_) begin
    if (reset && push)
      mem[wr_ptr_reg] <= {Rx_err, data};
  end

  always_ff @(posedge Bclkx16_) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rx_done_reg <= 1'b1;
      overrun_reg <= 1'b0;
    end else begin
      rx_done_reg <= Rx_done;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop)
        overrun_reg <= 1'b1;
      else if (clr_ovr)
        overrun_reg <= 1'b0;
    end
  end

  // Reset-pulse FSM. Every push event, including a dropped one, (re)loads
  // the counter so a frame arriving mid-pulse stretches rst low.
  always_comb begin
    state_next     = state_reg;
    pulse_cnt_next = pulse_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (push_ev && (RST_PULSE > 0)) begin
          state_next     = PULSE;
          pulse_cnt_next = PC_W'(RST_PULSE);
        end
      end
      PULSE: begin
        if (push_ev) begin
          pulse_cnt_next = PC_W'(RST_PULSE);
        end else begin
          pulse_cnt_next = pulse_cnt_reg - 1'b1;
          if (pulse_cnt_next == '0)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Bclkx16_) begin
    if (!reset) begin
      state_reg     <= IDLE;
      pulse_cnt_reg <= '0;
      rst_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pulse_cnt_reg <= pulse_cnt_next;
      // Registered: low from the cycle after the event while in PULSE.
      rst_reg       <= (state_next != PULSE);
    end
  end

  assign head      = mem[rd_ptr_reg];
  assign dis_valid = ~empty;
  assign dis       = empty ? '0 : head[DATA_W-1:0];
  assign dis_err   = empty ? 1'b0 : head[DATA_W];
  assign count     = count_reg;
  assign overrun   = overrun_reg;
  assign rst       = rst_reg;

endmodule

// File: tb/tb_rx_capture_fifo.sv
module tb_rx_capture_fifo;

  localparam int DEPTH = 4;
  localparam int RST_PULSE = 2;

  logic       clk = 1'b0;
  logic       reset, Rx_done, Rx_err, dis_ack, clr_ovr;
  logic [7:0] data;
  logic       rst, dis_err, dis_valid, overrun;
  logic [7:0] dis;
  logic [2:0] count;
  logic       rst0, dis_err0, dis_valid0, overrun0;
  logic [7:0] dis0;
  logic [2:0] count0;

  always #5 clk = ~clk;

  rx_capture_fifo #(.DATA_W(8), .DEPTH(DEPTH), .RST_PULSE(RST_PULSE)) dut (
    .Bclkx16_(clk), .reset(reset), .Rx_done(Rx_done), .Rx_err(Rx_err),
    .data(data), .dis_ack(dis_ack), .clr_ovr(clr_ovr), .rst(rst),
    .dis(dis), .dis_err(dis_err), .dis_valid(dis_valid), .count(count),
    .overrun(overrun)
  );

  // Same stimulus with the receiver reset pulse disabled.
  rx_capture_fifo #(.DATA_W(8), .DEPTH(DEPTH), .RST_PULSE(0)) dut0 (
    .Bclkx16_(clk), .reset(reset), .Rx_done(Rx_done), .Rx_err(Rx_err),
    .data(data), .dis_ack(dis_ack), .clr_ovr(clr_ovr), .rst(rst0),
    .dis(dis0), .dis_err(dis_err0), .dis_valid(dis_valid0), .count(count0),
    .overrun(overrun0)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: queue of {err,data}, sticky overrun, cycles of rst low left.
  logic [8:0] q[$];
  logic       e_ovr = 1'b0;
  logic       e_rst = 1'b0;
  logic       e_rst0 = 1'b0;
  logic       m_prev = 1'b1;
  int         m_left = 0;

  function automatic logic [15:0] exp_vec();
    logic [8:0] h;
    h = (q.size() > 0) ? q[0] : 9'd0;
    return {e_rst0, e_rst, e_ovr, q.size() > 0, 3'(q.size()), h[8], h[7:0]};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {rst0, rst, overrun, dis_valid, count, dis_err, dis};
  endfunction

  // Drive one cycle of inputs, clock it, advance the model, settle.
  task automatic step(input logic done, input logic err, input logic [7:0] d,
                      input logic ack, input logic clr, input logic rstn);
    logic ev, pop, full, drop;
    Rx_done = done; Rx_err = err; data = d; dis_ack = ack; clr_ovr = clr; reset = rstn;
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      q.delete(); e_ovr = 1'b0; m_left = 0; m_prev = 1'b1; e_rst = 1'b0; e_rst0 = 1'b0;
    end else begin
      ev = done && !m_prev;
      m_prev = done;
      full = (q.size() == DEPTH);
      pop = ack && (q.size() > 0);
      drop = 1'b0;
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (!full || pop) q.push_back({err, d});
        else drop = 1'b1;
      end
      if (drop) e_ovr = 1'b1;
      else if (clr) e_ovr = 1'b0;
      m_left = ev ? RST_PULSE : ((m_left > 0) ? m_left - 1 : 0);
      e_rst = (m_left == 0);
      e_rst0 = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_state cyc %0d: got %h required %h", cyc, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if ({rst, rst0, count, dis_valid, overrun, dis} !== 15'h0) begin
      n_fail++; $display("FAIL reset_values: got %h required 0", {rst, rst0, count, dis_valid, overrun, dis});
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (rst !== 1'b1 || rst0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: got rst=%b rst0=%b required 1", rst, rst0);
    end
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_held_done();
    logic [2:0] rst_req;
    rst_req = 3'b100;  // rst after each of the 3 held cycles: 0,0,1
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL held_done cyc %0d: got %h required %h", cyc, obs_vec(), exp_vec());
      end
      n_chk++;
      if (dis !== 8'hA5 || count !== 3'd1 || dis_valid !== 1'b1 || rst !== rst_req[i]) begin
        n_fail++; $display("FAIL held_done_direct %0d: got dis=%h count=%0d valid=%b rst=%b required A5 1 1 %b",
                           i, dis, count, dis_valid, rst, rst_req[i]);
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if (obs_vec() !== exp_vec() || count !== 3'd0) begin
      n_fail++; $display("FAIL held_done_drain: got %h required %h", obs_vec(), exp_vec());
    end
    $display("test_held_done done at cycle %0d", cyc);
  endtask

  task automatic test_order();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 1), vals[i], 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL order_push cyc %0d: got %h required %h", cyc, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (dis !== vals[i] || dis_err !== (i == 1) || count !== 3'(3 - i)) begin
        n_fail++; $display("FAIL order_head %0d: got dis=%h err=%b count=%0d required %h %b %0d",
                           i, dis, dis_err, count, vals[i], (i == 1), 3 - i);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL order_pop cyc %0d: got %h required %h", cyc, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (dis_valid !== 1'b0 || dis !== 8'h00 || count !== 3'd0) begin
      n_fail++; $display("FAIL order_empty: got valid=%b dis=%h count=%0d required 0 00 0", dis_valid, dis, count);
    end
    $display("test_order done at cycle %0d", cyc);
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 6; i++) begin
      // The sixth frame is dropped while clr_ovr is also high.
      step(1'b1, 1'b0, 8'(i), 1'b0, (i == 6), 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL overrun_fill cyc %0d: got %h required %h", cyc, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (count !== 3'd4 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set: got count=%0d ovr=%b required 4 1", count, overrun);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    n_chk++;
    if (overrun !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL overrun_clear: got ovr=%b required 0", overrun);
    end
    for (int i = 1; i <= 4; i++) begin
      n_chk++;
      if (dis !== 8'(i)) begin
        n_fail++; $display("FAIL overrun_drain %0d: got %h required %h", i, dis, 8'(i));
      end
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    end
    n_chk++;
    if (dis_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL overrun_empty: got valid=%b required 0", dis_valid);
    end
    $display("test_overrun done at cycle %0d", cyc);
  endtask

  task automatic test_push_pop_same();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if (count !== 3'd4 || overrun !== 1'b0 || dis !== 8'hA1 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL full_push_pop: got count=%0d ovr=%b dis=%h required 4 0 A1", count, overrun, dis);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if (dis !== 8'hEE || count !== 3'd1) begin
      n_fail++; $display("FAIL full_push_pop_last: got dis=%h count=%0d required EE 1", dis, count);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h7C, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if (count !== 3'd1 || dis !== 8'h7C || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL empty_push_ack: got count=%0d dis=%h required 1 7C", count, dis);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    $display("test_push_pop_same done at cycle %0d", cyc);
  endtask

  task automatic test_pulse();
    logic [6:0] done_pat, rst_req;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    done_pat = 7'b0000101;  // bit i applies to cycle i
    rst_req  = 7'b1110000;  // rst low through two cycles after the second edge
    for (int i = 0; i < 7; i++) begin
      step(done_pat[i], 1'b0, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (rst !== rst_req[i] || rst0 !== 1'b1 || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pulse_extend %0d: got rst=%b rst0=%b required %b 1", i, rst, rst0, rst_req[i]);
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(!i[0], 1'b0, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (count !== 3'd3 || rst !== 1'b0) begin
      n_fail++; $display("FAIL pulse_prefill: got count=%0d rst=%b required 3 0", count, rst);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (count !== 3'd0 || dis_valid !== 1'b0 || rst !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL mid_pulse_reset: got count=%0d valid=%b rst=%b required 0 0 0", count, dis_valid, rst);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (rst !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL mid_pulse_release: got rst=%b required 1", rst);
    end
    $display("test_pulse done at cycle %0d", cyc);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 4, 1'($urandom), 8'($urandom), $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0, $urandom_range(0, 99) != 0);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h required %h", cyc, obs_vec(), exp_vec());
      end
    end
    $display("test_random done at cycle %0d", cyc);
  endtask

  initial begin
    reset = 1'b0; Rx_done = 1'b0; Rx_err = 1'b0; data = 8'h00; dis_ack = 1'b0; clr_ovr = 1'b0;
    test_reset();
    test_held_done();
    test_order();
    test_overrun();
    test_push_pop_same();
    test_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
